// File: rtl/move_commit_if.sv
// Move request channel and board read/write bus between the move controller and its environment.
// The controller sits on the slave side; the requester and board memory sit on the master side.
interface move_commit_if #(
  parameter int unsigned COORD_W = 4
);
  logic               move_valid;
  logic               move_ready;
  logic [COORD_W-1:0] move_x;
  logic [COORD_W-1:0] move_y;

  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  logic [1:0]         rd_data;

  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [1:0]         wr_data;
  logic               write_enable;

  modport master (
    output move_valid, move_x, move_y, rd_data,
    input  move_ready, rd_x, rd_y, wr_x, wr_y, wr_data, write_enable
  );

  modport slave (
    input  move_valid, move_x, move_y, rd_data,
    output move_ready, rd_x, rd_y, wr_x, wr_y, wr_data, write_enable
  );
endinterface

// File: rtl/move_commit_ctrl.sv
// Move sequencer in front of the board memory: checks the target point, commits the current
// player's stone or rejects the move, alternates turns, and sweeps the board clear on new_game.
module move_commit_ctrl #(
  parameter int unsigned COORD_W      = 4,
  parameter logic [1:0]  FIRST_PLAYER = 2'b01
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               game_over,
  move_commit_if.slave       bus,
  output logic [1:0]         current_player,
  output logic [2*COORD_W:0] move_count,
  output logic               accept_pulse,
  output logic               reject_pulse,
  output logic               clearing,
  output logic               board_full
);

  localparam int unsigned IdxW = 2 * COORD_W;
  localparam logic [IdxW:0] NumPoints = {1'b1, {IdxW{1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StWrite,
    StClear
  } state_e;

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [1:0]         player_q, player_d;
  logic [IdxW:0]      count_q, count_d;

  // Last driven write address/data, so wr_* hold steady between writes.
  logic [COORD_W-1:0] wr_x_q, wr_x_d;
  logic [COORD_W-1:0] wr_y_q, wr_y_d;
  logic [1:0]         wr_data_q, wr_data_d;

  logic               move_ready;
  logic               write_enable;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [1:0]         wr_data;

  assign board_full = (count_q == NumPoints);
  assign move_ready = (state_q == StIdle) && !game_over && !board_full && !new_game;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    player_d     = player_q;
    count_d      = count_q;
    write_enable = 1'b0;
    wr_x         = wr_x_q;
    wr_y         = wr_y_q;
    wr_data      = wr_data_q;
    accept_pulse = 1'b0;
    reject_pulse = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (new_game) begin
          state_d = StClear;
          idx_d   = '0;
        end else if (bus.move_valid && move_ready) begin
          x_d     = bus.move_x;
          y_d     = bus.move_y;
          state_d = StCheck;
        end
      end

      StCheck: begin
        if (new_game) begin
          state_d = StClear;
          idx_d   = '0;
        end else if (bus.rd_data == 2'b00) begin
          state_d = StWrite;
        end else begin
          // Any non-empty code, including the illegal 2'b11, refuses the move.
          reject_pulse = 1'b1;
          state_d      = StIdle;
        end
      end

      StWrite: begin
        if (new_game) begin
          state_d = StClear;
          idx_d   = '0;
        end else begin
          write_enable = 1'b1;
          wr_x         = x_q;
          wr_y         = y_q;
          wr_data      = player_q;
          accept_pulse = 1'b1;
          player_d     = {player_q[0], player_q[1]};
          if (!board_full) begin
            count_d = count_q + 1'b1;
          end
          state_d = StIdle;
        end
      end

      StClear: begin
        write_enable = 1'b1;
        wr_x         = idx_q[IdxW-1:COORD_W];
        wr_y         = idx_q[COORD_W-1:0];
        wr_data      = 2'b00;
        if (new_game) begin
          idx_d = '0;
        end else if (idx_q == {IdxW{1'b1}}) begin
          idx_d    = '0;
          player_d = FIRST_PLAYER;
          count_d  = '0;
          state_d  = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    wr_x_d    = wr_x;
    wr_y_d    = wr_y;
    wr_data_d = wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      player_q  <= FIRST_PLAYER;
      count_q   <= '0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      idx_q     <= idx_d;
      player_q  <= player_d;
      count_q   <= count_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.move_ready   = move_ready;
  assign bus.rd_x         = x_q;
  assign bus.rd_y         = y_q;
  assign bus.wr_x         = wr_x;
  assign bus.wr_y         = wr_y;
  assign bus.wr_data      = wr_data;
  assign bus.write_enable = write_enable;

  assign current_player = player_q;
  assign move_count     = count_q;
  assign clearing       = (state_q == StClear);

  a_pulse_excl: assert property (@(posedge clock) disable iff (reset)
    !(accept_pulse && reject_pulse));
  a_no_pulse_in_clear: assert property (@(posedge clock) disable iff (reset)
    clearing |-> !(accept_pulse || reject_pulse));
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    move_count <= NumPoints);

endmodule

// File: tb/tb_move_commit_ctrl.sv
// Randomised bench for move_commit_ctrl: a bench-owned board memory plus a move-level reference
// model (board contents, player to move, accepted count) predicting every observed cycle.
module tb_move_commit_ctrl;

  localparam logic [1:0] First = 2'b01;

  logic       clock;
  logic       reset;
  logic       new_game;
  logic       game_over;
  logic [1:0] current_player;
  logic [8:0] move_count;
  logic       accept_pulse;
  logic       reject_pulse;
  logic       clearing;
  logic       board_full;

  move_commit_if #(.COORD_W(4)) bus ();

  move_commit_ctrl #(
    .COORD_W      (4),
    .FIRST_PLAYER (First)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .new_game       (new_game),
    .game_over      (game_over),
    .bus            (bus),
    .current_player (current_player),
    .move_count     (move_count),
    .accept_pulse   (accept_pulse),
    .reject_pulse   (reject_pulse),
    .clearing       (clearing),
    .board_full     (board_full)
  );

  // Board memory, reset together with the controller; poke_* plants arbitrary codes.
  logic [1:0] mem [256];
  logic       poke_en;
  logic [7:0] poke_idx;
  logic [1:0] poke_val;

  assign bus.rd_data = mem[{bus.rd_x, bus.rd_y}];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 2'b00;
    end else begin
      if (bus.write_enable) mem[{bus.wr_x, bus.wr_y}] <= bus.wr_data;
      if (poke_en) mem[poke_idx] <= poke_val;
    end
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model
  int         ref_board [256];
  logic [1:0] ref_player;
  int         ref_count;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_ref();
    for (int i = 0; i < 256; i++) ref_board[i] = 0;
    ref_player = First;
    ref_count  = 0;
  endtask

  // Starts in the first CLEAR cycle; optionally fires async reset part-way through.
  task automatic expect_sweep(input int reset_at);
    for (int i = 0; i < 256; i++) begin
      @(negedge clock);
      check_eq("sweep", {clearing, bus.write_enable, bus.wr_x, bus.wr_y, bus.wr_data,
                         accept_pulse, reject_pulse}, {2'b11, 8'(i), 2'b00, 2'b00});
      if (i == reset_at) begin
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mid_clear", {bus.write_enable, clearing, accept_pulse, reject_pulse}, 0);
        check_eq("rst_state", {current_player, move_count, bus.move_ready},
                 {First, 9'd0, !game_over});
        reset_ref();
        @(posedge clock);
        #1 reset = 1'b0;
        return;
      end
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    check_eq("sweep_done", {clearing, bus.write_enable, current_player, move_count,
                            bus.move_ready}, {2'b00, First, 9'd0, !game_over});
    reset_ref();
  endtask

  task automatic clear_from_idle(input int reset_at);
    @(posedge clock);
    #1;
    game_over = 1'b0;
    new_game  = 1'b1;
    @(negedge clock);
    check_eq("ng_idle", {bus.move_ready, bus.write_enable, accept_pulse, reject_pulse}, 0);
    @(posedge clock);
    #1 new_game = 1'b0;
    expect_sweep(reset_at);
  endtask

  task automatic poke(input int idx, input logic [1:0] val);
    @(posedge clock);
    #1;
    poke_en  = 1'b1;
    poke_idx = 8'(idx);
    poke_val = val;
    @(posedge clock);
    #1 poke_en = 1'b0;
    ref_board[idx] = int'(val);
  endtask

  // abort_at: 0 none, 1 new_game in the cycle after handshake, 2 two cycles after.
  task automatic do_move(input int x, input int y, input bit go_now, input bit go_mid,
                         input int abort_at);
    int   idx;
    bit   occupied;
    logic exp_ready;
    idx = x * 16 + y;
    @(posedge clock);
    #1;
    game_over      = go_now;
    bus.move_valid = 1'b1;
    bus.move_x     = 4'(x);
    bus.move_y     = 4'(y);
    @(negedge clock);
    exp_ready = !go_now && (ref_count < 256);
    check_eq("move_ready", bus.move_ready, exp_ready);
    @(posedge clock);
    #1 bus.move_valid = 1'b0;
    if (!exp_ready) begin
      @(negedge clock);
      check_eq("blocked", {bus.write_enable, accept_pulse, reject_pulse, move_count},
               {3'b000, 9'(ref_count)});
      return;
    end
    if (go_mid) game_over = 1'b1;
    if (abort_at == 1) new_game = 1'b1;
    occupied = (ref_board[idx] != 0);
    @(negedge clock);
    check_eq("rd_addr", {bus.rd_x, bus.rd_y}, idx);
    if (abort_at == 1) begin
      check_eq("abort_check", {bus.write_enable, accept_pulse, reject_pulse}, 0);
      @(posedge clock);
      #1 new_game = 1'b0;
      expect_sweep(-1);
      return;
    end
    check_eq("check_cycle", {bus.write_enable, accept_pulse, reject_pulse},
             {2'b00, occupied});
    @(posedge clock);
    #1;
    if (abort_at == 2) new_game = 1'b1;
    @(negedge clock);
    if (abort_at == 2) begin
      check_eq("abort_late", {bus.move_ready, bus.write_enable, accept_pulse, reject_pulse}, 0);
      @(posedge clock);
      #1 new_game = 1'b0;
      expect_sweep(-1);
      return;
    end
    if (occupied) begin
      check_eq("after_reject", {bus.move_ready, bus.write_enable, accept_pulse, reject_pulse,
                                current_player, move_count},
               {!game_over, 3'b000, ref_player, 9'(ref_count)});
      return;
    end
    check_eq("write", {bus.write_enable, bus.wr_x, bus.wr_y, bus.wr_data, accept_pulse,
                       reject_pulse}, {1'b1, 4'(x), 4'(y), ref_player, 2'b10});
    ref_board[idx] = int'(ref_player);
    ref_player     = (ref_player == 2'b01) ? 2'b10 : 2'b01;
    ref_count      = ref_count + 1;
    @(posedge clock);
    #1;
    @(negedge clock);
    exp_ready = !game_over && (ref_count < 256);
    check_eq("after_accept", {bus.move_ready, bus.write_enable, accept_pulse, current_player,
                              move_count}, {exp_ready, 2'b00, ref_player, 9'(ref_count)});
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (int'(mem[i]) != ref_board[i]) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    new_game       = 1'b0;
    game_over      = 1'b0;
    poke_en        = 1'b0;
    poke_idx       = 8'd0;
    poke_val       = 2'b00;
    bus.move_valid = 1'b0;
    bus.move_x     = 4'd0;
    bus.move_y     = 4'd0;
    reset_ref();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_ctrl", {bus.move_ready, bus.write_enable, accept_pulse, reject_pulse,
                          clearing, board_full}, 6'b100000);
    check_eq("rst_state", {current_player, move_count}, {First, 9'd0});
    check_eq("rst_addr", {bus.rd_x, bus.rd_y, bus.wr_x, bus.wr_y, bus.wr_data}, 0);

    // First move, replay of the same point, then a few more before clearing.
    do_move(3, 5, 1'b0, 1'b0, 0);
    do_move(3, 5, 1'b0, 1'b0, 0);
    do_move(0, 0, 1'b0, 1'b0, 0);
    do_move(15, 15, 1'b0, 1'b0, 0);
    do_move(7, 8, 1'b0, 1'b0, 0);
    check_board("board_4moves");
    clear_from_idle(-1);
    check_board("board_cleared");

    // new_game abandons an in-flight move, in CHECK and in WRITE.
    do_move(2, 2, 1'b0, 1'b0, 1);
    do_move(9, 1, 1'b0, 1'b0, 2);
    check_board("board_after_abort");

    // game_over blocks acceptance; a mid-move rise does not abort.
    do_move(6, 6, 1'b1, 1'b0, 0);
    do_move(6, 6, 1'b0, 1'b0, 0);
    do_move(6, 7, 1'b0, 1'b1, 0);
    do_move(6, 8, 1'b1, 1'b0, 0);

    // Illegal code in memory is treated as occupied.
    poke(4 * 16 + 4, 2'b11);
    do_move(4, 4, 1'b0, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      int r;
      int x;
      int y;
      r = int'($urandom_range(0, 99));
      x = int'($urandom_range(0, 3)) * 5;
      y = int'($urandom_range(0, 3)) * 4 + 1;
      if (r < 4) begin
        clear_from_idle(-1);
      end else if (r < 9) begin
        poke(x * 16 + y, ($urandom_range(0, 1) == 0) ? 2'b11 : 2'b10);
      end else begin
        do_move(x, y, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
    end
    check_board("board_random");

    // Fill every point; the controller must then refuse further moves.
    clear_from_idle(-1);
    for (int i = 0; i < 256; i++) do_move(i / 16, i % 16, 1'b0, 1'b0, 0);
    check_eq("full_flag", {board_full, move_count}, {1'b1, 9'd256});
    do_move(0, 0, 1'b0, 1'b0, 0);
    check_eq("full_sat", {board_full, move_count}, {1'b1, 9'd256});
    check_board("board_full");

    // Async reset part-way through a clear sweep.
    clear_from_idle(100);
    @(negedge clock);
    check_eq("post_rst", {clearing, bus.write_enable, current_player, move_count},
             {2'b00, First, 9'd0});
    do_move(1, 2, 1'b0, 1'b0, 0);
    check_board("board_post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
